// File: rtl/vpe_res_argmax.sv
// ---------------------------------------------------------------------------
// vpe_res_argmax
// Reduces each VPE inference result vector to a class label. Incoming words
// are buffered in a small FIFO (the VPE cannot be stalled). A sequential
// engine scans one signed lane per cycle and presents {label, max value} to
// the deparser over a valid/ready handshake.
//
// Ports
//   clk, rst_n    clock, async active-low reset
//   i_inf_res     result vector, lane i = bits [LANE_W*i +: LANE_W]
//   i_inf_res_v   push strobe, one word per cycle, never stalled
//   i_num_class   lanes to scan (0 -> 1, >LANES -> LANES), sampled in LOAD
//   i_out_rdy     deparser ready
//   o_label       argmax lane index
//   o_max_val     value of the winning lane
//   o_label_v     label valid, held until accepted
//   o_busy        engine not idle or FIFO not empty
//   o_overflow    sticky, a push was dropped on a full FIFO
//   o_fifo_cnt    FIFO occupancy
//   o_label_cnt   labels accepted by the deparser, wrapping
// ---------------------------------------------------------------------------
module vpe_res_argmax #(
   parameter  int unsigned LANES      = 16,
   parameter  int unsigned LANE_W     = 16,
   parameter  int unsigned IDX_W      = 4,
   parameter  int unsigned FIFO_DEPTH = 8,
   localparam int unsigned WORD_W     = LANES * LANE_W,
   localparam int unsigned NC_W       = IDX_W + 1,
   localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH),
   localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1),
   localparam int unsigned LCNT_W     = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [WORD_W-1:0]   i_inf_res,
   input  logic                i_inf_res_v,
   input  logic [NC_W-1:0]     i_num_class,
   input  logic                i_out_rdy,
   output logic [IDX_W-1:0]    o_label,
   output logic [LANE_W-1:0]   o_max_val,
   output logic                o_label_v,
   output logic                o_busy,
   output logic                o_overflow,
   output logic [CNT_W-1:0]    o_fifo_cnt,
   output logic [LCNT_W-1:0]   o_label_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SCAN = 2'd2,
      OUT  = 2'd3
   } state_t;

   state_t               state;

   // FIFO storage and control
   logic [WORD_W-1:0]    mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     count;
   logic                 empty_c;
   logic                 full_c;
   logic                 pop_c;
   logic                 push_c;
   logic                 drop_c;

   // Engine working state
   logic [WORD_W-1:0]    word;
   logic [NC_W-1:0]      nc;
   logic [IDX_W-1:0]     cnt;
   logic [IDX_W-1:0]     idx;
   logic [LANE_W-1:0]    best;
   logic [LCNT_W-1:0]    label_cnt;

   logic [LANE_W-1:0]    lanes_c [LANES];
   logic [LANE_W-1:0]    lane_c;
   logic [NC_W-1:0]      nc_c;
   logic                 gt_c;
   logic                 last_c;

   // FIFO status; a pop in the same cycle frees a slot for a push at full
   assign empty_c = (count == '0);
   assign full_c  = (count == CNT_W'(FIFO_DEPTH));
   assign pop_c   = (state == IDLE) && !empty_c;
   assign push_c  = i_inf_res_v && (!full_c || pop_c);
   assign drop_c  = i_inf_res_v && full_c && !pop_c;

   // Lane view of the working word
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign lanes_c[g] = word[g*LANE_W +: LANE_W];
   end

   assign lane_c = lanes_c[cnt];
   assign gt_c   = $signed(lane_c) > $signed(best);
   assign last_c = ({1'b0, cnt} == (nc - NC_W'(1)));

   // Clamp the requested class count into 1..LANES
   always_comb begin
      nc_c = i_num_class;
      if (i_num_class == '0) begin
         nc_c = NC_W'(1);
      end else if (i_num_class > NC_W'(LANES)) begin
         nc_c = NC_W'(LANES);
      end
   end

   // FIFO data array; no reset needed, occupancy is tracked by count
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[wr_ptr] <= i_inf_res;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push_c && !pop_c) begin
            count <= count + CNT_W'(1);
         end else if (pop_c && !push_c) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   // Argmax engine: IDLE -> LOAD -> SCAN* -> OUT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         word      <= '0;
         nc        <= '0;
         cnt       <= '0;
         idx       <= '0;
         best      <= '0;
         label_cnt <= '0;
         o_label   <= '0;
         o_max_val <= '0;
         o_label_v <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pop_c) begin
                  word  <= mem[rd_ptr];
                  state <= LOAD;
               end
            end
            LOAD: begin
               nc   <= nc_c;
               best <= lanes_c[0];
               idx  <= '0;
               cnt  <= IDX_W'(1);
               if (nc_c == NC_W'(1)) begin
                  o_label   <= '0;
                  o_max_val <= lanes_c[0];
                  o_label_v <= 1'b1;
                  state     <= OUT;
               end else begin
                  state <= SCAN;
               end
            end
            SCAN: begin
               if (gt_c) begin
                  best <= lane_c;
                  idx  <= cnt;
               end
               if (last_c) begin
                  // Final lane: publish the winner including this compare
                  o_label   <= gt_c ? cnt : idx;
                  o_max_val <= gt_c ? lane_c : best;
                  o_label_v <= 1'b1;
                  state     <= OUT;
               end else begin
                  cnt <= cnt + IDX_W'(1);
               end
            end
            OUT: begin
               if (i_out_rdy) begin
                  o_label_v <= 1'b0;
                  label_cnt <= label_cnt + LCNT_W'(1);
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Status outputs, one cycle behind the state they report
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_busy      <= 1'b0;
         o_fifo_cnt  <= '0;
         o_label_cnt <= '0;
         o_overflow  <= 1'b0;
      end else begin
         o_busy      <= (state != IDLE) || !empty_c;
         o_fifo_cnt  <= count;
         o_label_cnt <= label_cnt;
         if (drop_c) begin
            o_overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vpe_res_argmax.sv
// ---------------------------------------------------------------------------
// tb_vpe_res_argmax
// Scoreboard bench for vpe_res_argmax: expected {label, max} pushed when a
// word is driven, popped and compared when the deparser handshake completes.
// ---------------------------------------------------------------------------
module tb_vpe_res_argmax;

   logic          clk;
   logic          rst_n;
   logic [255:0]  i_inf_res;
   logic          i_inf_res_v;
   logic [4:0]    i_num_class;
   logic          i_out_rdy;
   logic [3:0]    o_label;
   logic [15:0]   o_max_val;
   logic          o_label_v;
   logic          o_busy;
   logic          o_overflow;
   logic [3:0]    o_fifo_cnt;
   logic [15:0]   o_label_cnt;

   vpe_res_argmax dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_inf_res   (i_inf_res),
      .i_inf_res_v (i_inf_res_v),
      .i_num_class (i_num_class),
      .i_out_rdy   (i_out_rdy),
      .o_label     (o_label),
      .o_max_val   (o_max_val),
      .o_label_v   (o_label_v),
      .o_busy      (o_busy),
      .o_overflow  (o_overflow),
      .o_fifo_cnt  (o_fifo_cnt),
      .o_label_cnt (o_label_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          cyc;
   int          n_cmp;
   int          n_err;
   logic [19:0] sb_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference argmax: strict signed greater-than, lowest index wins ties
   function automatic logic [19:0] model(input logic [255:0] w, input logic [4:0] nc_in);
      int                 n;
      logic signed [15:0] bv;
      logic signed [15:0] v;
      logic [3:0]         bi;
      if (nc_in == 5'd0)       n = 1;
      else if (nc_in > 5'd16)  n = 16;
      else                     n = int'(nc_in);
      bv = w[15:0];
      bi = 4'd0;
      for (int i = 1; i < n; i++) begin
         v = w[i*16 +: 16];
         if (v > bv) begin
            bv = v;
            bi = 4'(i);
         end
      end
      return {bi, bv};
   endfunction

   // Scoreboard: compare at each accepted handshake
   always @(negedge clk) begin
      if (rst_n && o_label_v && i_out_rdy) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_label", 32'd1, 32'd0);
         end else begin
            chk("label", 32'(o_label), 32'(sb_q[0][19:16]));
            chk("max_val", 32'(o_max_val), 32'(sb_q[0][15:0]));
            void'(sb_q.pop_front());
         end
      end
   end

   task automatic push_word(input logic [255:0] w, input bit keep);
      @(posedge clk); #1;
      i_inf_res   = w;
      i_inf_res_v = 1'b1;
      if (keep) sb_q.push_back(model(w, i_num_class));
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
      i_inf_res_v = 1'b0;
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while ((sb_q.size() != 0 || o_busy || o_label_v) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 3000) chk(tag, 32'd0, 32'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n       = 1'b0;
      i_inf_res_v = 1'b0;
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Push one word into an idle engine and measure cycles to o_label_v
   task automatic lat_test(input logic [255:0] w, input logic [4:0] nc,
                           input int exp_lat, input string tag);
      int  t0;
      int  lat;
      bit  found;
      i_num_class = nc;
      push_word(w, 1'b1);
      t0 = cyc;
      idle_cycle();
      found = 1'b0;
      lat   = -1;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge clk);
         if (o_label_v) begin
            found = 1'b1;
            lat   = cyc - t0;
         end
      end
      chk(tag, 32'(lat), 32'(exp_lat));
      drain({tag, "_drain"});
   endtask

   initial begin
      logic [255:0] w;
      int           hi_cnt;

      cyc         = 0;
      n_cmp       = 0;
      n_err       = 0;
      rst_n       = 1'b0;
      i_inf_res   = '0;
      i_inf_res_v = 1'b0;
      i_num_class = 5'd16;
      i_out_rdy   = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_label_v", 32'(o_label_v), 32'd0);
      chk("rst_label", 32'(o_label), 32'd0);
      chk("rst_max_val", 32'(o_max_val), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_overflow", 32'(o_overflow), 32'd0);
      chk("rst_fifo_cnt", 32'(o_fifo_cnt), 32'd0);
      chk("rst_label_cnt", 32'(o_label_cnt), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // T1 basic
      for (int i = 0; i < 16; i++) w[i*16 +: 16] = 16'(i * 3);
      w[9*16 +: 16] = 16'h0100;
      lat_test(w, 5'd16, 18, "t1_latency");

      // T2 tie and signed compare
      for (int i = 0; i < 16; i++) w[i*16 +: 16] = 16'hFFF0;
      w[2*16 +: 16] = 16'h0040;
      w[5*16 +: 16] = 16'h0040;
      lat_test(w, 5'd16, 18, "t2_tie_latency");
      for (int i = 0; i < 16; i++) w[i*16 +: 16] = 16'h8000;
      lat_test(w, 5'd16, 18, "t2_min_latency");

      // T3 clamping
      for (int i = 0; i < 16; i++) w[i*16 +: 16] = 16'(i);
      w[3*16 +: 16]  = 16'd7;
      w[10*16 +: 16] = 16'h7000;
      lat_test(w, 5'd4, 6, "t3_nc4_latency");
      for (int i = 0; i < 16; i++) w[i*16 +: 16] = 16'(100 - i);
      w[0] = 1'b0;
      lat_test(w, 5'd0, 3, "t3_nc0_latency");
      for (int i = 0; i < 16; i++) w[i*16 +: 16] = 16'(i * 2);
      w[15*16 +: 16] = 16'h0200;
      lat_test(w, 5'd31, 18, "t3_nc31_latency");
      chk("t3_label_cnt", 32'(o_label_cnt), 32'd6);

      // T4 backpressure
      do_reset();
      i_num_class = 5'd16;
      i_out_rdy   = 1'b0;
      for (int n = 0; n < 3; n++) begin
         for (int i = 0; i < 16; i++) w[i*16 +: 16] = 16'($urandom);
         push_word(w, 1'b1);
         idle_cycle();
      end
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("t4_label_v_held", 32'(o_label_v), 32'd1);
      chk("t4_fifo_cnt", 32'(o_fifo_cnt), 32'd2);
      chk("t4_busy", 32'(o_busy), 32'd1);
      chk("t4_label_hold", 32'(o_label), 32'(sb_q[0][19:16]));
      chk("t4_max_hold", 32'(o_max_val), 32'(sb_q[0][15:0]));
      @(posedge clk); #1;
      i_out_rdy = 1'b1;
      drain("t4_drain");
      chk("t4_label_cnt", 32'(o_label_cnt), 32'd3);

      // T5 overflow
      do_reset();
      i_out_rdy = 1'b0;
      for (int n = 0; n < 10; n++) begin
         for (int i = 0; i < 16; i++) w[i*16 +: 16] = 16'($urandom);
         push_word(w, n < 9);
      end
      idle_cycle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("t5_fifo_cnt", 32'(o_fifo_cnt), 32'd8);
      chk("t5_overflow", 32'(o_overflow), 32'd1);
      @(posedge clk); #1;
      i_out_rdy = 1'b1;
      drain("t5_drain");
      chk("t5_label_cnt", 32'(o_label_cnt), 32'd9);
      chk("t5_overflow_sticky", 32'(o_overflow), 32'd1);

      // T6 reset during a scan with words queued
      for (int n = 0; n < 3; n++) begin
         for (int i = 0; i < 16; i++) w[i*16 +: 16] = 16'($urandom);
         push_word(w, 1'b1);
      end
      idle_cycle();
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      chk("t6_label_v", 32'(o_label_v), 32'd0);
      chk("t6_fifo_cnt", 32'(o_fifo_cnt), 32'd0);
      chk("t6_label_cnt", 32'(o_label_cnt), 32'd0);
      chk("t6_overflow_clr", 32'(o_overflow), 32'd0);
      chk("t6_busy", 32'(o_busy), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      hi_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (o_label_v) hi_cnt++;
      end
      chk("t6_no_stale_label", 32'(hi_cnt), 32'd0);
      chk("t6_fifo_empty", 32'(o_fifo_cnt), 32'd0);

      // Engine still healthy after the mid-scan reset
      for (int i = 0; i < 16; i++) w[i*16 +: 16] = 16'(16'h0010 + 16'(i));
      w[6*16 +: 16] = 16'h7FFF;
      lat_test(w, 5'd16, 18, "t6_post_latency");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
